// File: rtl/cpu_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_bus_arbiter
//  Description : Multi-master CPU bus arbiter with fixed-priority or
//                round-robin grant, one-hot region decode and an open-bus
//                read-data latch.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_bus_arbiter #(
   parameter int NUM_MASTERS = 2,
   parameter int NUM_REGIONS = 3,
   parameter int AW          = 16,
   parameter int DW          = 8,
   parameter int ARB_MODE    = 0,
   parameter logic [NUM_REGIONS*AW-1:0] REGION_BASE = {16'h8000, 16'h2000, 16'h0000},
   parameter logic [NUM_REGIONS*AW-1:0] REGION_MASK = {16'h8000, 16'hE000, 16'hE000}
) (
   input  logic                      clk_in,
   input  logic                      rst_in,
   input  logic [NUM_MASTERS-1:0]    mst_req_in,
   input  logic [NUM_MASTERS*AW-1:0] mst_a_in,
   input  logic [NUM_MASTERS-1:0]    mst_r_nw_in,
   input  logic [NUM_MASTERS*DW-1:0] mst_d_in,
   output logic [NUM_MASTERS-1:0]    mst_gnt_out,
   output logic [DW-1:0]             rd_d_out,
   output logic [AW-1:0]             bus_a_out,
   output logic                      bus_r_nw_out,
   output logic [DW-1:0]             bus_d_out,
   output logic [NUM_REGIONS-1:0]    slv_sel_out,
   input  logic [NUM_REGIONS*DW-1:0] slv_d_in,
   output logic                      busy_out
);

   localparam int OW = $clog2(NUM_MASTERS);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_OWN  = 2'd1;
   localparam logic [1:0] S_GAP  = 2'd2;

   logic [1:0]    r_state;
   logic [OW-1:0] r_owner;
   logic [OW-1:0] r_last_owner;
   logic          r_rd_hit;
   logic [DW-1:0] r_open_bus;

   logic          w_own;
   logic          w_win_found;
   logic [OW-1:0] w_winner;
   logic          w_owner_req;
   logic [AW-1:0] w_own_a;
   logic          w_own_r_nw;
   logic [DW-1:0] w_own_d;
   logic [NUM_REGIONS-1:0] w_sel;
   logic [DW-1:0] w_slv_or;

   assign w_own = (r_state == S_OWN);

   // Winner selection: either the lowest requesting index, or the first
   // requester found after the previous owner (round-robin).
   generate
      if (ARB_MODE == 0) begin : g_fixed
         always_comb begin
            w_winner    = '0;
            w_win_found = 1'b0;
            for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
               if (mst_req_in[i]) begin
                  w_winner    = OW'(i);
                  w_win_found = 1'b1;
               end
            end
         end
      end else begin : g_rr
         always_comb begin
            int idx;
            w_winner    = '0;
            w_win_found = 1'b0;
            idx         = 0;
            // Walk backwards so the nearest candidate after last owner wins.
            for (int k = NUM_MASTERS; k >= 1; k--) begin
               idx = (int'(r_last_owner) + k) % NUM_MASTERS;
               if (mst_req_in[idx]) begin
                  w_winner    = OW'(idx);
                  w_win_found = 1'b1;
               end
            end
         end
      end
   endgenerate

   // Select the current owner's request, address, direction and write data.
   always_comb begin
      w_owner_req = 1'b0;
      w_own_a     = '0;
      w_own_r_nw  = 1'b1;
      w_own_d     = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (r_owner == OW'(i)) begin
            w_owner_req = mst_req_in[i];
            w_own_a     = mst_a_in[i*AW +: AW];
            w_own_r_nw  = mst_r_nw_in[i];
            w_own_d     = mst_d_in[i*DW +: DW];
         end
      end
   end

   // Bus outputs follow the owner only in OWN; otherwise the bus is parked.
   always_comb begin
      bus_a_out    = w_own ? w_own_a    : '0;
      bus_r_nw_out = w_own ? w_own_r_nw : 1'b1;
      bus_d_out    = w_own ? w_own_d    : '0;
      busy_out     = w_own;
      mst_gnt_out  = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         mst_gnt_out[i] = w_own && (r_owner == OW'(i));
      end
   end

   // Region decode: descending scan so the lowest matching region wins.
   always_comb begin
      w_sel = '0;
      for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
         if ((bus_a_out & REGION_MASK[i*AW +: AW]) == REGION_BASE[i*AW +: AW]) begin
            w_sel    = '0;
            w_sel[i] = 1'b1;
         end
      end
      slv_sel_out = w_own ? w_sel : '0;
   end

   // Unselected slaves drive zero, so a plain OR recovers the read data.
   always_comb begin
      w_slv_or = '0;
      for (int i = 0; i < NUM_REGIONS; i++) begin
         w_slv_or = w_slv_or | slv_d_in[i*DW +: DW];
      end
      rd_d_out = r_rd_hit ? w_slv_or : r_open_bus;
   end

   // Ownership state machine, round-robin history and read-return tracking.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_state      <= S_IDLE;
         r_owner      <= '0;
         r_last_owner <= OW'(NUM_MASTERS - 1);
         r_rd_hit     <= 1'b0;
         r_open_bus   <= '0;
      end else begin
         r_rd_hit <= w_own && bus_r_nw_out && (|slv_sel_out);
         if (r_rd_hit) begin
            r_open_bus <= w_slv_or;
         end
         case (r_state)
            S_IDLE: begin
               if (w_win_found) begin
                  r_state      <= S_OWN;
                  r_owner      <= w_winner;
                  r_last_owner <= w_winner;
               end
            end
            S_OWN: begin
               if (!w_owner_req) begin
                  r_state <= S_GAP;
               end
            end
            S_GAP: begin
               if (w_win_found) begin
                  r_state      <= S_OWN;
                  r_owner      <= w_winner;
                  r_last_owner <= w_winner;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
